// File: rtl/mem_access_pkg.sv
// Shared types for the memory stage: decoded ops, access sizes and the data bus payloads.
package mem_access_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned DST_W  = 5;
    localparam int unsigned STRB_W = XLEN / 8;

    typedef enum logic [3:0] {
        OP_NOP, OP_ADD,
        OP_LB, OP_LH, OP_LW, OP_LD,
        OP_LBU, OP_LHU, OP_LWU,
        OP_SB, OP_SH, OP_SW, OP_SD
    } op_t;

    typedef enum logic [1:0] {
        MSIZE1, MSIZE2, MSIZE4, MSIZE8
    } msize_t;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   addr;
        msize_t            size;
        logic [STRB_W-1:0] strobe;
        logic [XLEN-1:0]   data;
    } dbus_req_t;

    typedef struct packed {
        logic            addr_ok;
        logic            data_ok;
        logic [XLEN-1:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic   is_mem;
        logic   is_load;
        logic   is_signed;
        msize_t size;
    } op_info_t;

    // Access class of an op: memory/load/signed flags and transfer size.
    function automatic op_info_t decode_op(input op_t op);
        op_info_t info;
        info = '{is_mem: 1'b0, is_load: 1'b0, is_signed: 1'b0, size: MSIZE1};
        case (op)
            OP_LB:   info = '{is_mem: 1'b1, is_load: 1'b1, is_signed: 1'b1, size: MSIZE1};
            OP_LH:   info = '{is_mem: 1'b1, is_load: 1'b1, is_signed: 1'b1, size: MSIZE2};
            OP_LW:   info = '{is_mem: 1'b1, is_load: 1'b1, is_signed: 1'b1, size: MSIZE4};
            OP_LD:   info = '{is_mem: 1'b1, is_load: 1'b1, is_signed: 1'b1, size: MSIZE8};
            OP_LBU:  info = '{is_mem: 1'b1, is_load: 1'b1, is_signed: 1'b0, size: MSIZE1};
            OP_LHU:  info = '{is_mem: 1'b1, is_load: 1'b1, is_signed: 1'b0, size: MSIZE2};
            OP_LWU:  info = '{is_mem: 1'b1, is_load: 1'b1, is_signed: 1'b0, size: MSIZE4};
            OP_SB:   info = '{is_mem: 1'b1, is_load: 1'b0, is_signed: 1'b0, size: MSIZE1};
            OP_SH:   info = '{is_mem: 1'b1, is_load: 1'b0, is_signed: 1'b0, size: MSIZE2};
            OP_SW:   info = '{is_mem: 1'b1, is_load: 1'b0, is_signed: 1'b0, size: MSIZE4};
            OP_SD:   info = '{is_mem: 1'b1, is_load: 1'b0, is_signed: 1'b0, size: MSIZE8};
            default: info = '{is_mem: 1'b0, is_load: 1'b0, is_signed: 1'b0, size: MSIZE1};
        endcase
        return info;
    endfunction

    function automatic logic is_misaligned(input msize_t size, input logic [2:0] a);
        logic mis;
        case (size)
            MSIZE2:  mis = a[0];
            MSIZE4:  mis = |a[1:0];
            MSIZE8:  mis = |a;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane alignment: store strobe/data placement and load extract with sign/zero extension.
module mem_align
    import mem_access_pkg::*;
(
    input  op_t               op,
    input  logic [2:0]        addr_lo,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata_raw,
    output logic [STRB_W-1:0] strobe_c,
    output logic [XLEN-1:0]   wdata_c,
    output logic [XLEN-1:0]   rdata_c
);

    op_info_t        info;
    logic [5:0]      shamt;
    logic [XLEN-1:0] rshift;

    always_comb begin
        info     = decode_op(op);
        shamt    = {addr_lo, 3'b000};
        rshift   = rdata_raw >> shamt;
        strobe_c = '0;
        wdata_c  = '0;
        rdata_c  = '0;

        if (info.is_mem && !info.is_load) begin
            wdata_c = wdata << shamt;
            case (info.size)
                MSIZE1:  strobe_c = STRB_W'(8'h01) << addr_lo;
                MSIZE2:  strobe_c = STRB_W'(8'h03) << addr_lo;
                MSIZE4:  strobe_c = STRB_W'(8'h0F) << addr_lo;
                default: strobe_c = STRB_W'(8'hFF);
            endcase
        end

        if (info.is_load) begin
            case (info.size)
                MSIZE1:  rdata_c = {{56{info.is_signed & rshift[7]}},  rshift[7:0]};
                MSIZE2:  rdata_c = {{48{info.is_signed & rshift[15]}}, rshift[15:0]};
                MSIZE4:  rdata_c = {{32{info.is_signed & rshift[31]}}, rshift[31:0]};
                default: rdata_c = rshift;
            endcase
        end
    end

endmodule

// File: rtl/mem_access.sv
// Memory pipeline stage: accepts one op, runs a single outstanding dbus transaction, returns one result.
module mem_access
    import mem_access_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_t              in_op,
    input  logic [XLEN-1:0]  in_addr,
    input  logic [XLEN-1:0]  in_wdata,
    input  logic [DST_W-1:0] in_dst,
    output logic             out_valid,
    output logic [XLEN-1:0]  out_rdata,
    output logic [DST_W-1:0] out_dst,
    output logic             out_misalign,
    output dbus_req_t        dreq,
    input  dbus_resp_t       dresp
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic [DST_W-1:0] dst_q, dst_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_rdata_q, out_rdata_d;
    logic [DST_W-1:0] out_dst_q, out_dst_d;
    logic             out_misalign_q, out_misalign_d;
    logic             mem_done;

    logic [STRB_W-1:0] strobe_c;
    logic [XLEN-1:0]   store_data_c;
    logic [XLEN-1:0]   load_data_c;

    mem_align u_align (
        .op        (op_q),
        .addr_lo   (addr_q[2:0]),
        .wdata     (wdata_q),
        .rdata_raw (dresp.data),
        .strobe_c  (strobe_c),
        .wdata_c   (store_data_c),
        .rdata_c   (load_data_c)
    );

    // Request fields come only from latched state, so they hold until data_ok.
    assign dreq = '{valid:  (state_q != ST_IDLE),
                    addr:   addr_q,
                    size:   decode_op(op_q).size,
                    strobe: strobe_c,
                    data:   store_data_c};

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_rdata    = out_rdata_q;
    assign out_dst      = out_dst_q;
    assign out_misalign = out_misalign_q;

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        dst_d          = dst_q;
        out_valid_d    = 1'b0;
        out_rdata_d    = '0;
        out_dst_d      = '0;
        out_misalign_d = 1'b0;
        mem_done       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    op_d    = in_op;
                    addr_d  = in_addr;
                    wdata_d = in_wdata;
                    dst_d   = in_dst;
                    if (!decode_op(in_op).is_mem) begin
                        out_valid_d = 1'b1;
                        out_dst_d   = in_dst;
                    end else if (is_misaligned(decode_op(in_op).size, in_addr[2:0])) begin
                        out_valid_d    = 1'b1;
                        out_misalign_d = 1'b1;
                        out_dst_d      = decode_op(in_op).is_load ? in_dst : '0;
                        mem_done       = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (dresp.addr_ok) begin
                    if (dresp.data_ok) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b1;
                        out_rdata_d = load_data_c;
                        out_dst_d   = decode_op(op_q).is_load ? dst_q : '0;
                        mem_done    = 1'b1;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (dresp.data_ok) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b1;
                    out_rdata_d = load_data_c;
                    out_dst_d   = decode_op(op_q).is_load ? dst_q : '0;
                    mem_done    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A finishing memory op blocks the next accept for its result cycle.
        in_ready_d = (state_d == ST_IDLE) && !mem_done;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            op_q           <= OP_NOP;
            addr_q         <= '0;
            wdata_q        <= '0;
            dst_q          <= '0;
            in_ready_q     <= 1'b1;
            out_valid_q    <= 1'b0;
            out_rdata_q    <= '0;
            out_dst_q      <= '0;
            out_misalign_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            dst_q          <= dst_d;
            in_ready_q     <= in_ready_d;
            out_valid_q    <= out_valid_d;
            out_rdata_q    <= out_rdata_d;
            out_dst_q      <= out_dst_d;
            out_misalign_q <= out_misalign_d;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: stores, loads, misalignment, bus stalls and reset mid-transaction.
module tb_mem_access;
    import mem_access_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    op_t              in_op;
    logic [63:0]      in_addr;
    logic [63:0]      in_wdata;
    logic [4:0]       in_dst;
    logic             out_valid;
    logic [63:0]      out_rdata;
    logic [4:0]       out_dst;
    logic             out_misalign;
    dbus_req_t        dreq;
    dbus_resp_t       dresp;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_addr      (in_addr),
        .in_wdata     (in_wdata),
        .in_dst       (in_dst),
        .out_valid    (out_valid),
        .out_rdata    (out_rdata),
        .out_dst      (out_dst),
        .out_misalign (out_misalign),
        .dreq         (dreq),
        .dresp        (dresp)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_req(input string tag, input logic [63:0] addr, input msize_t size,
                             input logic [7:0] strb, input logic [63:0] data);
        check_eq({tag, "_req_valid"}, 64'(dreq.valid), 64'd1);
        check_eq({tag, "_req_addr"}, dreq.addr, addr);
        check_eq({tag, "_req_size"}, 64'(dreq.size), 64'(size));
        check_eq({tag, "_req_strobe"}, 64'(dreq.strobe), 64'(strb));
        check_eq({tag, "_req_data"}, dreq.data, data);
        check_eq({tag, "_wait_out_valid"}, 64'(out_valid), 64'd0);
        check_eq({tag, "_wait_in_ready"}, 64'(in_ready), 64'd0);
    endtask

    // One aligned memory op: addr_ok after a_dly idle cycles, data_ok d_dly cycles after addr_ok.
    task automatic mem_op(input string tag, input op_t op, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [4:0] dst,
                          input int a_dly, input int d_dly, input logic [63:0] rsp,
                          input msize_t exp_size, input logic [7:0] exp_strb,
                          input logic [63:0] exp_data, input logic [63:0] exp_rdata,
                          input logic [4:0] exp_dst);
        check_eq({tag, "_accept_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wdata; in_dst = dst;
        tick();
        in_valid = 1'b0; in_op = OP_NOP;
        check_req(tag, addr, exp_size, exp_strb, exp_data);
        for (int i = 0; i < a_dly; i++) begin
            tick();
            check_req(tag, addr, exp_size, exp_strb, exp_data);
        end
        dresp.addr_ok = 1'b1;
        dresp.data_ok = (d_dly == 0);
        if (d_dly == 0) dresp.data = rsp;
        tick();
        dresp.addr_ok = 1'b0;
        dresp.data_ok = 1'b0;
        if (d_dly > 0) begin
            for (int i = 1; i < d_dly; i++) begin
                check_req(tag, addr, exp_size, exp_strb, exp_data);
                tick();
            end
            check_req(tag, addr, exp_size, exp_strb, exp_data);
            dresp.data_ok = 1'b1;
            dresp.data    = rsp;
            tick();
            dresp.data_ok = 1'b0;
        end
        dresp.data = 64'h5A5A_5A5A_5A5A_5A5A;
        check_eq({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        check_eq({tag, "_out_rdata"}, out_rdata, exp_rdata);
        check_eq({tag, "_out_dst"}, 64'(out_dst), 64'(exp_dst));
        check_eq({tag, "_out_misalign"}, 64'(out_misalign), 64'd0);
        check_eq({tag, "_done_in_ready"}, 64'(in_ready), 64'd0);
        check_eq({tag, "_done_req_valid"}, 64'(dreq.valid), 64'd0);
        tick();
        check_eq({tag, "_pulse_end"}, 64'(out_valid), 64'd0);
        check_eq({tag, "_ready_again"}, 64'(in_ready), 64'd1);
    endtask

    task automatic misaligned_op(input string tag, input op_t op, input logic [63:0] addr,
                                 input logic [4:0] dst, input logic [4:0] exp_dst);
        check_eq({tag, "_accept_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = 64'hFFFF_0000_FFFF_0000; in_dst = dst;
        tick();
        in_valid = 1'b0; in_op = OP_NOP;
        check_eq({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        check_eq({tag, "_out_misalign"}, 64'(out_misalign), 64'd1);
        check_eq({tag, "_out_rdata"}, out_rdata, 64'd0);
        check_eq({tag, "_out_dst"}, 64'(out_dst), 64'(exp_dst));
        check_eq({tag, "_req_valid"}, 64'(dreq.valid), 64'd0);
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        tick();
        check_eq({tag, "_pulse_end"}, 64'(out_valid), 64'd0);
        check_eq({tag, "_req_valid2"}, 64'(dreq.valid), 64'd0);
        check_eq({tag, "_ready_again"}, 64'(in_ready), 64'd1);
    endtask

    task automatic add_op(input string tag, input logic [4:0] dst);
        check_eq({tag, "_accept_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_op = OP_ADD; in_addr = 64'h1234; in_wdata = 64'h99; in_dst = dst;
        tick();
        in_valid = 1'b0; in_op = OP_NOP;
        check_eq({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        check_eq({tag, "_out_dst"}, 64'(out_dst), 64'(dst));
        check_eq({tag, "_out_rdata"}, out_rdata, 64'd0);
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check_eq({tag, "_req_valid"}, 64'(dreq.valid), 64'd0);
        tick();
        check_eq({tag, "_pulse_end"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_op = OP_NOP; in_addr = '0; in_wdata = '0; in_dst = '0;
        dresp = '0;
        tick();
        tick();
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_rdata", out_rdata, 64'd0);
        check_eq("rst_out_dst", 64'(out_dst), 64'd0);
        check_eq("rst_out_misalign", 64'(out_misalign), 64'd0);
        check_eq("rst_req_valid", 64'(dreq.valid), 64'd0);
        reset = 1'b0;
        tick();

        mem_op("sd", OP_SD, 64'h8000_0008, 64'h1122_3344_5566_7788, 5'd7, 0, 0, 64'h0,
               MSIZE8, 8'hFF, 64'h1122_3344_5566_7788, 64'h0, 5'd0);
        mem_op("sb", OP_SB, 64'h8000_0003, 64'h0000_0000_0000_00AB, 5'd7, 1, 1, 64'h0,
               MSIZE1, 8'h08, 64'h0000_0000_AB00_0000, 64'h0, 5'd0);
        mem_op("sh", OP_SH, 64'h8000_0002, 64'h0000_0000_0000_1234, 5'd1, 0, 1, 64'h0,
               MSIZE2, 8'h0C, 64'h0000_0000_1234_0000, 64'h0, 5'd0);
        mem_op("sw", OP_SW, 64'h8000_0004, 64'h0000_0000_CAFE_BABE, 5'd1, 0, 0, 64'h0,
               MSIZE4, 8'hF0, 64'hCAFE_BABE_0000_0000, 64'h0, 5'd0);
        mem_op("lb", OP_LB, 64'h8000_0005, 64'h7777, 5'd5, 0, 0, 64'h0000_8000_0000_0000,
               MSIZE1, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 5'd5);
        mem_op("lbu", OP_LBU, 64'h8000_0005, 64'h7777, 5'd6, 0, 1, 64'h0000_8000_0000_0000,
               MSIZE1, 8'h00, 64'h0, 64'h0000_0000_0000_0080, 5'd6);
        mem_op("lh", OP_LH, 64'h8000_0006, 64'h0, 5'd8, 1, 0, 64'h8001_0000_0000_0000,
               MSIZE2, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 5'd8);
        mem_op("lwu", OP_LWU, 64'h8000_0004, 64'h0, 5'd10, 0, 0, 64'h89AB_CDEF_0000_0000,
               MSIZE4, 8'h00, 64'h0, 64'h0000_0000_89AB_CDEF, 5'd10);
        mem_op("ld_stall", OP_LD, 64'h8000_0010, 64'h0, 5'd11, 3, 2, 64'hDEAD_BEEF_CAFE_F00D,
               MSIZE8, 8'h00, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 5'd11);

        misaligned_op("lw_mis", OP_LW, 64'h8000_0002, 5'd4, 5'd4);
        misaligned_op("sd_mis", OP_SD, 64'h8000_0004, 5'd4, 5'd0);

        // Reset while the response is outstanding, then a stray data_ok.
        in_valid = 1'b1; in_op = OP_LW; in_addr = 64'h0000_0100; in_wdata = '0; in_dst = 5'd3;
        tick();
        in_valid = 1'b0; in_op = OP_NOP;
        dresp.addr_ok = 1'b1;
        tick();
        dresp.addr_ok = 1'b0;
        check_eq("rr_resp_req_valid", 64'(dreq.valid), 64'd1);
        check_eq("rr_resp_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("rr_req_valid", 64'(dreq.valid), 64'd0);
        check_eq("rr_in_ready", 64'(in_ready), 64'd1);
        check_eq("rr_out_valid", 64'(out_valid), 64'd0);
        dresp.data_ok = 1'b1;
        dresp.data    = 64'h0000_0000_1111_2222;
        tick();
        dresp.data_ok = 1'b0;
        check_eq("rr_late_out_valid", 64'(out_valid), 64'd0);
        check_eq("rr_late_req_valid", 64'(dreq.valid), 64'd0);
        tick();
        check_eq("rr_late_out_valid2", 64'(out_valid), 64'd0);
        add_op("rr_add", 5'd9);
        add_op("add2", 5'd31);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
